// File: rtl/sccb_pkg.sv
// sccb_pkg: shared FSM state type, ID direction bits and slot-phase helpers for the SCCB master
package sccb_pkg;

    typedef enum logic [2:0] {IDLE, START, BYTE, STOP, GAP} state_t;

    localparam logic ID_WR = 1'b0;
    localparam logic ID_RD = 1'b1;

    // Counter values at which each quarter-slot strobe fires (last cycle before the phase boundary)
    function automatic int q1_cnt(input int div);
        return div / 4 - 1;
    endfunction

    function automatic int half_cnt(input int div);
        return div / 2 - 1;
    endfunction

    function automatic int q3_cnt(input int div);
        return 3 * div / 4 - 1;
    endfunction

endpackage

// File: rtl/sccb_bit_timer.sv
// sccb_bit_timer: per-slot cycle counter producing quarter-phase strobes for the SCCB FSM
module sccb_bit_timer
    import sccb_pkg::*;
#(
    parameter int CLK_DIV = 120
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic q1_o,
    output logic half_o,
    output logic q3_o,
    output logic slot_end_o
);

    localparam int W = $clog2(CLK_DIV);

    logic [W-1:0] cnt_q;

    // Count through one bit slot, wrapping at the slot end; parked at 0 while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= (!run_i || slot_end_o) ? '0 : cnt_q + 1'b1;
    end

    // Strobes mark the last cycle before each phase boundary of the slot
    always_comb begin
        q1_o       = run_i && cnt_q == W'(q1_cnt(CLK_DIV));
        half_o     = run_i && cnt_q == W'(half_cnt(CLK_DIV));
        q3_o       = run_i && cnt_q == W'(q3_cnt(CLK_DIV));
        slot_end_o = run_i && cnt_q == W'(CLK_DIV - 1);
    end

endmodule

// File: rtl/sccb_master.sv
// sccb_master: SCCB master issuing 3-phase writes and 2-phase reads to a camera sensor
module sccb_master
    import sccb_pkg::*;
#(
    parameter int         CLK_DIV    = 120,
    parameter logic [6:0] DEV_ID     = 7'h21,
    parameter int         ADDR_BYTES = 1,
    parameter int         ACK_CHECK  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ren,
    input  logic                    wen,
    input  logic [8*ADDR_BYTES-1:0] sub_addr,
    input  logic [7:0]              wdata,
    output logic [7:0]              rdata,
    output logic                    rdata_vld,
    output logic                    rdy,
    output logic                    ack_err,
    output logic                    sio_c,
    input  logic                    sio_d_r,
    output logic                    sio_d_w,
    output logic                    en_sio_d_w
);

    if (CLK_DIV % 4 != 0 || CLK_DIV < 8) begin : g_bad_div
        $error("sccb_master: CLK_DIV must be a multiple of 4 and at least 8");
    end
    if (ADDR_BYTES != 1 && ADDR_BYTES != 2) begin : g_bad_addr
        $error("sccb_master: ADDR_BYTES must be 1 or 2");
    end

    state_t                  state_q;
    logic                    rd_q, phase2_q, rdy_q, rdata_vld_q, ack_err_q;
    logic                    sio_c_q, sio_d_q, en_q;
    logic [1:0]              byte_q;
    logic [3:0]              bit_q;
    logic [8*ADDR_BYTES-1:0] addr_q;
    logic [7:0]              wdata_q, rx_q, rdata_q;

    logic                    q1, half, q3, slot_end;
    logic [1:0]              last_byte, byte_d;
    logic [3:0]              bit_d;
    logic                    rx, rx_d, en_d, last;
    logic [8*(ADDR_BYTES+2)-1:0] frame;
    logic [7:0]              tx;

    sccb_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (state_q != IDLE),
        .q1_o       (q1),
        .half_o     (half),
        .q3_o       (q3),
        .slot_end_o (slot_end)
    );

    // Byte sequencing: which byte is on the wire, where the next slot lands and whether SIO_D is released there
    always_comb begin
        frame     = {DEV_ID, phase2_q ? ID_RD : ID_WR, addr_q, wdata_q};
        tx        = frame[8*(ADDR_BYTES + 1 - int'(byte_q)) +: 8];
        last_byte = phase2_q ? 2'd1 : rd_q ? 2'(ADDR_BYTES) : 2'(ADDR_BYTES + 1);
        last      = bit_q == 4'd8 && byte_q == last_byte;
        byte_d    = bit_q == 4'd8 ? byte_q + 2'd1 : byte_q;
        bit_d     = bit_q == 4'd8 ? 4'd0 : bit_q + 4'd1;
        rx        = phase2_q && byte_q == 2'd1;
        rx_d      = phase2_q && byte_d == 2'd1;
        en_d      = !((rx_d && bit_d != 4'd8) || (ACK_CHECK != 0 && !rx_d && bit_d == 4'd8));
    end

    // Transaction FSM with registered bus and handshake outputs, driven by the slot strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_q        <= 1'b0;
            phase2_q    <= 1'b0;
            byte_q      <= '0;
            bit_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rx_q        <= '0;
            rdata_q     <= '0;
            rdata_vld_q <= 1'b0;
            rdy_q       <= 1'b1;
            ack_err_q   <= 1'b0;
            sio_c_q     <= 1'b1;
            sio_d_q     <= 1'b1;
            en_q        <= 1'b0;
        end else begin
            rdata_vld_q <= 1'b0;
            case (state_q)
                IDLE: if (rdy_q && (ren || wen)) begin
                    state_q   <= START;
                    rd_q      <= !wen;
                    phase2_q  <= 1'b0;
                    byte_q    <= '0;
                    bit_q     <= '0;
                    addr_q    <= sub_addr;
                    wdata_q   <= wdata;
                    ack_err_q <= 1'b0;
                    rdy_q     <= 1'b0;
                    en_q      <= 1'b1;
                end
                START: begin
                    if (half) sio_d_q <= 1'b0;
                    if (slot_end) begin
                        state_q <= BYTE;
                        sio_c_q <= 1'b0;
                    end
                end
                BYTE: begin
                    if (q1) sio_d_q <= (bit_q == 4'd8 || rx) ? 1'b1 : tx[3'd7 - bit_q[2:0]];
                    if (half) sio_c_q <= 1'b1;
                    if (q3 && rx && bit_q != 4'd8) rx_q <= {rx_q[6:0], sio_d_r};
                    if (q3 && ACK_CHECK != 0 && !rx && bit_q == 4'd8 && sio_d_r) ack_err_q <= 1'b1;
                    if (slot_end) begin
                        sio_c_q <= 1'b0;
                        if (last) begin
                            state_q <= STOP;
                            en_q    <= 1'b1;
                        end else begin
                            byte_q <= byte_d;
                            bit_q  <= bit_d;
                            en_q   <= en_d;
                        end
                    end
                end
                STOP: begin
                    if (q1) sio_d_q <= 1'b0;
                    if (half) sio_c_q <= 1'b1;
                    if (q3) sio_d_q <= 1'b1;
                    if (slot_end) begin
                        byte_q <= '0;
                        bit_q  <= '0;
                        if (rd_q && !phase2_q) begin
                            state_q  <= GAP;
                            phase2_q <= 1'b1;
                        end else begin
                            state_q     <= IDLE;
                            en_q        <= 1'b0;
                            rdy_q       <= 1'b1;
                            rdata_vld_q <= rd_q;
                            if (rd_q) rdata_q <= rx_q;
                        end
                    end
                end
                GAP: if (slot_end) state_q <= START;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rdata      = rdata_q;
    assign rdata_vld  = rdata_vld_q;
    assign rdy        = rdy_q;
    assign ack_err    = ack_err_q;
    assign sio_c      = sio_c_q;
    assign sio_d_w    = sio_d_q;
    assign en_sio_d_w = en_q;

endmodule

// File: tb/tb_sccb_master.sv
// tb_sccb_master: directed tests of sccb_master with a bus decoder and a simple slave model
module tb_sccb_master;

    logic clk = 1'b0, rst_n = 1'b0;
    logic a_ren = 0, a_wen = 0, b_ren = 0, b_wen = 0, c_ren = 0, c_wen = 0;
    logic [7:0]  a_addr = 0, c_addr = 0, a_wd = 0, b_wd = 0, c_wd = 0;
    logic [15:0] b_addr = 0;
    logic [7:0]  a_rdata, b_rdata, c_rdata;
    logic a_vld, a_rdy, a_err, a_sc, a_sw, a_en;
    logic b_vld, b_rdy, b_err, b_sc, b_sw, b_en;
    logic c_vld, c_rdy, c_err, c_sc, c_sw, c_en;
    logic sdrv = 1'b1;
    int   sel = 0;
    int   checks = 0, errors = 0;

    always #5 clk = ~clk;

    sccb_master #(.CLK_DIV(8)) u_a (
        .clk(clk), .rst_n(rst_n), .ren(a_ren), .wen(a_wen), .sub_addr(a_addr), .wdata(a_wd),
        .rdata(a_rdata), .rdata_vld(a_vld), .rdy(a_rdy), .ack_err(a_err), .sio_c(a_sc),
        .sio_d_r(a_en ? a_sw : sdrv), .sio_d_w(a_sw), .en_sio_d_w(a_en));

    sccb_master #(.CLK_DIV(8), .ADDR_BYTES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .ren(b_ren), .wen(b_wen), .sub_addr(b_addr), .wdata(b_wd),
        .rdata(b_rdata), .rdata_vld(b_vld), .rdy(b_rdy), .ack_err(b_err), .sio_c(b_sc),
        .sio_d_r(b_en ? b_sw : sdrv), .sio_d_w(b_sw), .en_sio_d_w(b_en));

    sccb_master #(.CLK_DIV(8), .ACK_CHECK(1)) u_c (
        .clk(clk), .rst_n(rst_n), .ren(c_ren), .wen(c_wen), .sub_addr(c_addr), .wdata(c_wd),
        .rdata(c_rdata), .rdata_vld(c_vld), .rdy(c_rdy), .ack_err(c_err), .sio_c(c_sc),
        .sio_d_r(c_en ? c_sw : sdrv), .sio_d_w(c_sw), .en_sio_d_w(c_en));

    logic sc_m, sw_m, en_m, rdy_m, vld_m, err_m, line_m;
    assign sc_m   = sel == 0 ? a_sc  : sel == 1 ? b_sc  : c_sc;
    assign sw_m   = sel == 0 ? a_sw  : sel == 1 ? b_sw  : c_sw;
    assign en_m   = sel == 0 ? a_en  : sel == 1 ? b_en  : c_en;
    assign rdy_m  = sel == 0 ? a_rdy : sel == 1 ? b_rdy : c_rdy;
    assign vld_m  = sel == 0 ? a_vld : sel == 1 ? b_vld : c_vld;
    assign err_m  = sel == 0 ? a_err : sel == 1 ? b_err : c_err;
    assign line_m = en_m ? sw_m : sdrv;

    // Bus decoder and slave: 256 = START, 257 = STOP, else a decoded byte
    int ev[$];
    int bitcnt = 0, nbytes = 0, nack_idx = -1, vld_cnt = 0;
    logic [7:0] shreg = 0, rd_val = 0;
    logic rd_mode = 0, prev_sc = 1, prev_sd = 1;

    initial forever begin
        @(negedge clk);
        if (prev_sc && sc_m && prev_sd && !line_m) begin
            ev.push_back(256); bitcnt = 0; nbytes = 0; rd_mode = 0;
        end else if (prev_sc && sc_m && !prev_sd && line_m) begin
            ev.push_back(257);
        end else if (!prev_sc && sc_m) begin
            if (bitcnt < 8) shreg = {shreg[6:0], line_m};
            bitcnt++;
            if (bitcnt == 9) begin
                ev.push_back(int'(shreg));
                rd_mode = nbytes == 0 && shreg == 8'h43;
                nbytes++;
                bitcnt = 0;
            end
        end else if (prev_sc && !sc_m) begin
            if (bitcnt == 8) sdrv = rd_mode || nbytes == nack_idx;
            else sdrv = rd_mode ? rd_val[7 - bitcnt] : 1'b1;
        end
        prev_sc = sc_m;
        prev_sd = line_m;
    end

    initial forever begin
        @(negedge clk);
        if (a_vld) vld_cnt++;
    end

    function automatic string ev_str(input int q[$]);
        string s = "";
        foreach (q[i]) begin
            if (q[i] == 256) s = {s, "S "};
            else if (q[i] == 257) s = {s, "P "};
            else s = {s, $sformatf("%02h ", q[i][7:0])};
        end
        return s;
    endfunction

    task automatic do_req(input int d, input logic r, input logic w, input logic [15:0] ad, input logic [7:0] wd);
        @(negedge clk);
        ev.delete();
        case (d)
            0: begin a_ren = r; a_wen = w; a_addr = ad[7:0]; a_wd = wd; end
            1: begin b_ren = r; b_wen = w; b_addr = ad; b_wd = wd; end
            default: begin c_ren = r; c_wen = w; c_addr = ad[7:0]; c_wd = wd; end
        endcase
        @(negedge clk);
        a_ren = 0; a_wen = 0; b_ren = 0; b_wen = 0; c_ren = 0; c_wen = 0;
    endtask

    task automatic wait_done(output int n, output int zeros, output int first0, output int early);
        n = 0; zeros = 0; first0 = -1; early = 0;
        while (!rdy_m && n < 2000) begin
            if (!en_m) begin zeros++; if (first0 < 0) first0 = n; end
            if (vld_m) early++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        sel = 0;
        checks += 7;
        if (a_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", a_rdy); end
        if (a_sc !== 1'b1) begin errors++; $display("FAIL reset_sio_c got %b want 1", a_sc); end
        if (a_sw !== 1'b1) begin errors++; $display("FAIL reset_sio_d_w got %b want 1", a_sw); end
        if (a_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", a_en); end
        if (a_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", a_rdata); end
        if (a_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", a_vld); end
        if (a_err !== 1'b0) begin errors++; $display("FAIL reset_ack_err got %b want 0", a_err); end
    endtask

    task automatic test_write;
        int n, z, f, e;
        sel = 0;
        do_req(0, 0, 1, 16'h0012, 8'h80);
        checks++;
        if (a_rdy !== 1'b0) begin errors++; $display("FAIL write_rdy_drop got %b want 0", a_rdy); end
        wait_done(n, z, f, e);
        checks += 5;
        if (n != 232) begin errors++; $display("FAIL write_len got %0d want 232", n); end
        if (ev_str(ev) != "S 42 12 80 P ") begin errors++; $display("FAIL write_bus got '%s' want 'S 42 12 80 P '", ev_str(ev)); end
        if (z != 0) begin errors++; $display("FAIL write_en_low got %0d want 0", z); end
        if (e != 0 || a_vld !== 1'b0) begin errors++; $display("FAIL write_vld got %0d/%b want 0/0", e, a_vld); end
        if (a_err !== 1'b0) begin errors++; $display("FAIL write_ack_err got %b want 0", a_err); end
    endtask

    task automatic test_read;
        int n, z, f, e, v0;
        sel = 0; rd_val = 8'h76; v0 = vld_cnt;
        do_req(0, 1, 0, 16'h000A, 8'h00);
        wait_done(n, z, f, e);
        checks += 6;
        if (n != 328) begin errors++; $display("FAIL read_len got %0d want 328", n); end
        if (ev_str(ev) != "S 42 0a P S 43 76 P ") begin errors++; $display("FAIL read_bus got '%s' want 'S 42 0a P S 43 76 P '", ev_str(ev)); end
        if (z != 64 || f != 248) begin errors++; $display("FAIL read_en_low got %0d@%0d want 64@248", z, f); end
        if (e != 0) begin errors++; $display("FAIL read_early_vld got %0d want 0", e); end
        if (a_vld !== 1'b1) begin errors++; $display("FAIL read_vld got %b want 1", a_vld); end
        if (a_rdata !== 8'h76) begin errors++; $display("FAIL read_rdata got %h want 76", a_rdata); end
        @(negedge clk);
        checks += 2;
        if (a_vld !== 1'b0) begin errors++; $display("FAIL read_vld_pulse got %b want 0", a_vld); end
        if (vld_cnt - v0 != 1 || a_rdata !== 8'h76) begin errors++; $display("FAIL read_vld_once got %0d/%h want 1/76", vld_cnt - v0, a_rdata); end
    endtask

    task automatic test_addr16;
        int n, z, f, e;
        sel = 1;
        do_req(1, 0, 1, 16'h3008, 8'h02);
        wait_done(n, z, f, e);
        checks += 2;
        if (n != 304) begin errors++; $display("FAIL addr16_len got %0d want 304", n); end
        if (ev_str(ev) != "S 42 30 08 02 P ") begin errors++; $display("FAIL addr16_bus got '%s' want 'S 42 30 08 02 P '", ev_str(ev)); end
    endtask

    task automatic test_nack;
        int n, z, f, e;
        sel = 2; nack_idx = 1;
        do_req(2, 0, 1, 16'h0012, 8'h80);
        wait_done(n, z, f, e);
        checks += 4;
        if (c_err !== 1'b1) begin errors++; $display("FAIL nack_err got %b want 1", c_err); end
        if (ev_str(ev) != "S 42 12 80 P ") begin errors++; $display("FAIL nack_bus got '%s' want 'S 42 12 80 P '", ev_str(ev)); end
        if (n != 232) begin errors++; $display("FAIL nack_len got %0d want 232", n); end
        if (z != 24) begin errors++; $display("FAIL nack_en_low got %0d want 24", z); end
        nack_idx = -1;
        do_req(2, 0, 1, 16'h0034, 8'h56);
        checks++;
        if (c_err !== 1'b0) begin errors++; $display("FAIL nack_clear got %b want 0", c_err); end
        wait_done(n, z, f, e);
        checks += 2;
        if (c_err !== 1'b0) begin errors++; $display("FAIL ack_ok_err got %b want 0", c_err); end
        if (ev_str(ev) != "S 42 34 56 P ") begin errors++; $display("FAIL ack_ok_bus got '%s' want 'S 42 34 56 P '", ev_str(ev)); end
    endtask

    task automatic test_back_to_back;
        int n, z, f, e;
        sel = 0;
        do_req(0, 1, 1, 16'h0055, 8'hAA);
        repeat (40) @(negedge clk);
        a_wen = 1; a_addr = 8'h99; a_wd = 8'h11;
        @(negedge clk);
        a_wen = 0;
        wait_done(n, z, f, e);
        checks += 3;
        if (n != 191) begin errors++; $display("FAIL both_len got %0d want 191", n); end
        if (ev_str(ev) != "S 42 55 aa P ") begin errors++; $display("FAIL both_bus got '%s' want 'S 42 55 aa P '", ev_str(ev)); end
        if (e != 0 || a_vld !== 1'b0) begin errors++; $display("FAIL both_vld got %0d/%b want 0/0", e, a_vld); end
        do_req(0, 0, 1, 16'h0001, 8'hFF);
        wait_done(n, z, f, e);
        checks += 2;
        if (n != 232) begin errors++; $display("FAIL b2b_len got %0d want 232", n); end
        if (ev_str(ev) != "S 42 01 ff P ") begin errors++; $display("FAIL b2b_bus got '%s' want 'S 42 01 ff P '", ev_str(ev)); end
        repeat (100) @(negedge clk);
        checks++;
        if (a_rdy !== 1'b1 || ev.size() != 5) begin errors++; $display("FAIL ignored_wen got rdy=%b events=%0d want 1/5", a_rdy, ev.size()); end
    endtask

    task automatic test_reset_mid;
        int n, z, f, e, v0;
        sel = 0; rd_val = 8'h5C; v0 = vld_cnt;
        do_req(0, 1, 0, 16'h0021, 8'h00);
        repeat (100) @(negedge clk);
        rst_n = 0;
        #1;
        checks += 6;
        if (a_sc !== 1'b1) begin errors++; $display("FAIL rst_sio_c got %b want 1", a_sc); end
        if (a_sw !== 1'b1) begin errors++; $display("FAIL rst_sio_d_w got %b want 1", a_sw); end
        if (a_en !== 1'b0) begin errors++; $display("FAIL rst_en got %b want 0", a_en); end
        if (a_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy got %b want 1", a_rdy); end
        if (a_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %b want 0", a_vld); end
        if (a_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h want 00", a_rdata); end
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (50) @(negedge clk);
        checks++;
        if (vld_cnt != v0 || a_rdy !== 1'b1) begin errors++; $display("FAIL rst_abandon got vld=%0d rdy=%b want 0/1", vld_cnt - v0, a_rdy); end
        do_req(0, 0, 1, 16'h0034, 8'h56);
        wait_done(n, z, f, e);
        checks += 2;
        if (n != 232) begin errors++; $display("FAIL post_rst_len got %0d want 232", n); end
        if (ev_str(ev) != "S 42 34 56 P ") begin errors++; $display("FAIL post_rst_bus got '%s' want 'S 42 34 56 P '", ev_str(ev)); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        test_reset;
        test_write;
        test_read;
        test_addr16;
        test_nack;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
